conv_out_collector: RTL and testbench

CONV_OUT_COLLECTOR -- requirements
Module: conv_out_collector

---
 rtl/conv_out_collector.sv | 152 +++++++++++++++
 tb/tb_conv_out_collector.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_collector.sv
// Collects one frame of convolution sums, rescales with bias/shift/ReLU/saturation,
// buffers OUT_SIZE*OUT_SIZE results and streams them out under valid/ready.
//
// state   | meaning
// IDLE    | waiting for i_start
// COLLECT | sampling i_en results into the buffer
// DRAIN   | streaming buffer entries 0..N-1 downstream
module conv_out_collector #(
    parameter int OUT_SIZE  = 3,
    parameter int IN_WIDTH  = 48,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_en,
    input  logic signed [IN_WIDTH-1:0]  i_P,
    input  logic signed [IN_WIDTH-1:0]  i_bias,
    input  logic                        i_relu_en,
    output logic                        o_valid,
    output logic signed [OUT_WIDTH-1:0] o_data,
    input  logic                        i_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_sat,
    output logic                        o_err
);

    localparam int N  = OUT_SIZE * OUT_SIZE;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    localparam logic signed [IN_WIDTH:0] MAXV = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MINV = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    state_t state, state_nx;

    logic [CW-1:0]               wr_cnt;
    logic [AW-1:0]               rd_addr;
    logic [AW-1:0]               pend_addr;
    logic                        pend;
    logic signed [OUT_WIDTH-1:0] pend_data;
    logic signed [OUT_WIDTH-1:0] res;
    logic                        clamp;
    logic signed [IN_WIDTH:0]    sum;
    logic signed [IN_WIDTH:0]    shifted;
    logic signed [OUT_WIDTH-1:0] mem [0:N-1];
    logic                        sample;
    logic                        en_err;
    logic                        last_write;
    logic                        last_accept;

    // One extra bit so bias addition can never wrap.
    assign sum     = {i_P[IN_WIDTH-1], i_P} + {i_bias[IN_WIDTH-1], i_bias};
    assign shifted = sum >>> SHIFT;

    always_comb begin
        res   = '0;
        clamp = 1'b0;
        if (i_relu_en && shifted[IN_WIDTH]) begin
            res = '0;
        end else if (shifted > MAXV) begin
            res   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            clamp = 1'b1;
        end else if (shifted < MINV) begin
            res   = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            clamp = 1'b1;
        end else begin
            res = shifted[OUT_WIDTH-1:0];
        end
    end

    assign sample      = (state == S_COLLECT) && i_en && !i_start && (wr_cnt != CW'(N));
    assign en_err      = i_en && !i_start && ((state != S_COLLECT) || (wr_cnt == CW'(N)));
    assign last_write  = pend && (pend_addr == AW'(N - 1));
    assign last_accept = (state == S_DRAIN) && o_valid && i_ready && (rd_addr == AW'(N - 1));
    assign o_busy      = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (i_start) state_nx = S_COLLECT;
            S_COLLECT: if (i_start) state_nx = S_COLLECT;
                       else if (last_write) state_nx = S_DRAIN;
            S_DRAIN:   if (i_start) state_nx = S_COLLECT;
                       else if (last_accept) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Buffer is not reset; every entry is rewritten before a drain reads it.
    always_ff @(posedge i_clk) begin
        if (pend) mem[pend_addr] <= pend_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_cnt    <= '0;
            rd_addr   <= '0;
            pend_addr <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_sat     <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            pend   <= 1'b0;
            if (i_start) begin
                wr_cnt  <= '0;
                rd_addr <= '0;
                o_valid <= 1'b0;
                o_sat   <= 1'b0;
                o_err   <= 1'b0;
            end else begin
                if (en_err) o_err <= 1'b1;
                if (sample) begin
                    pend      <= 1'b1;
                    pend_data <= res;
                    pend_addr <= wr_cnt[AW-1:0];
                    wr_cnt    <= wr_cnt + CW'(1);
                    if (clamp) o_sat <= 1'b1;
                end
                if (state == S_DRAIN) begin
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                        o_data  <= mem[rd_addr];
                    end else if (i_ready) begin
                        if (rd_addr == AW'(N - 1)) begin
                            o_valid <= 1'b0;
                            o_done  <= 1'b1;
                        end else begin
                            rd_addr <= rd_addr + AW'(1);
                            o_data  <= mem[rd_addr + AW'(1)];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector at OUT_SIZE=3, SHIFT=4, OUT_WIDTH=8.
module tb_conv_out_collector;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic              i_en;
    logic signed [47:0] i_P;
    logic signed [47:0] i_bias;
    logic              i_relu_en;
    logic              o_valid;
    logic signed [7:0] o_data;
    logic              i_ready;
    logic              o_busy;
    logic              o_done;
    logic              o_sat;
    logic              o_err;

    int n_checks = 0;
    int n_errors = 0;
    int got[$];

    conv_out_collector #(.OUT_SIZE(3), .IN_WIDTH(48), .OUT_WIDTH(8), .SHIFT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_en(i_en), .i_P(i_P),
        .i_bias(i_bias), .i_relu_en(i_relu_en), .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done), .o_sat(o_sat), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_pulse(input bit with_en);
        i_start = 1'b1;
        i_en    = with_en;
        tick();
        i_start = 1'b0;
        i_en    = 1'b0;
    endtask

    task automatic send_frame(input int v[9]);
        for (int k = 0; k < 9; k++) begin
            i_P  = v[k];
            i_en = 1'b1;
            tick();
        end
        i_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (!o_valid && c < 30) begin
            tick();
            c++;
        end
        check(tag, o_valid, 1);
    endtask

    // Accept the stream; in random mode i_ready toggles and held outputs are checked.
    task automatic collect(input bit rnd, output int dones, output int span);
        int first = -1;
        int last  = -1;
        bit stalled = 1'b0;
        bit r;
        logic signed [7:0] held = '0;
        got.delete();
        dones = 0;
        for (int c = 0; c < 300 && dones == 0; c++) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, held);
            end
            i_ready = r;
            if (o_valid && r) begin
                got.push_back(int'(o_data));
                if (first < 0) first = c;
                last = c;
            end
            stalled = o_valid && !r;
            held    = o_data;
            tick();
            if (o_done) dones++;
        end
        i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (o_done) dones++;
        end
        span = last - first;
    endtask

    task automatic expect_stream(input string tag, input int e[9]);
        check({tag, "_len"}, got.size(), 9);
        for (int k = 0; k < 9 && k < got.size(); k++)
            check($sformatf("%s_%0d", tag, k), got[k], e[k]);
    endtask

    initial begin
        int dones, span;
        int nom_in[9]  = '{0, 16, 32, 48, 64, 80, 96, 112, 128};
        int nom_ex[9]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        int sat_in[9]  = '{5000, -5000, 16, 32, -16, -32, 48, -1, 2047};
        int sat_ex[9]  = '{127, -128, 1, 2, -1, -2, 3, -1, 127};
        int rb_in[9]   = '{-5000, 32, 5000, 16, 0, 48, 2064, 2063, 15};
        int rb_ex[9]   = '{0, 1, 127, 0, 0, 2, 127, 127, 0};
        int rl_in[9]   = '{-5000, -1, 0, 16, 32, 48, 64, 80, 96};
        int rl_ex[9]   = '{0, 0, 0, 1, 2, 3, 4, 5, 6};
        int ab_in[9]   = '{160, 176, 192, 208, 224, 240, 256, 272, 288};
        int ab_ex[9]   = '{10, 11, 12, 13, 14, 15, 16, 17, 18};

        i_rst = 1'b1; i_start = 1'b0; i_en = 1'b0; i_P = '0; i_bias = '0;
        i_relu_en = 1'b0; i_ready = 1'b1;

        // Reset with random inputs
        for (int c = 0; c < 3; c++) begin
            i_start = 1'($urandom_range(0, 1));
            i_en    = 1'($urandom_range(0, 1));
            i_P     = 48'($urandom);
            i_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_sat", o_sat, 0);
        check("rst_err", o_err, 0);
        i_rst = 1'b0; i_start = 1'b0; i_en = 1'b0; i_P = '0; i_ready = 1'b1;
        tick();

        // Nominal
        start_pulse(1'b0);
        check("nom_busy", o_busy, 1);
        send_frame(nom_in);
        collect(1'b0, dones, span);
        expect_stream("nom", nom_ex);
        check("nom_dones", dones, 1);
        check("nom_span", span, 8);
        check("nom_sat", o_sat, 0);
        check("nom_err", o_err, 0);
        check("nom_idle", o_busy, 0);

        // Saturation, no ReLU
        start_pulse(1'b0);
        send_frame(sat_in);
        collect(1'b0, dones, span);
        expect_stream("sat", sat_ex);
        check("sat_flag", o_sat, 1);
        check("sat_dones", dones, 1);

        // ReLU with bias -16
        i_relu_en = 1'b1; i_bias = -16;
        start_pulse(1'b0);
        check("sat_cleared", o_sat, 0);
        send_frame(rb_in);
        collect(1'b0, dones, span);
        expect_stream("relu_bias", rb_ex);
        check("relu_bias_sat", o_sat, 1);

        // ReLU negatives must not flag saturation
        i_bias = 0;
        start_pulse(1'b0);
        send_frame(rl_in);
        collect(1'b0, dones, span);
        expect_stream("relu", rl_ex);
        check("relu_sat", o_sat, 0);
        i_relu_en = 1'b0;

        // Backpressure
        start_pulse(1'b0);
        send_frame(nom_in);
        collect(1'b1, dones, span);
        expect_stream("bp", nom_ex);
        check("bp_dones", dones, 1);

        // Abort mid-collect; restart coincident with i_en
        start_pulse(1'b0);
        for (int k = 0; k < 4; k++) begin
            i_P = 1600; i_en = 1'b1; tick();
        end
        i_en = 1'b0;
        start_pulse(1'b1);
        check("abort_err", o_err, 0);
        check("abort_busy", o_busy, 1);
        send_frame(ab_in);
        collect(1'b0, dones, span);
        expect_stream("abort", ab_ex);
        check("abort_dones", dones, 1);

        // Abort during drain
        start_pulse(1'b0);
        send_frame(nom_in);
        i_ready = 1'b0;
        wait_valid("dabort_valid_up");
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("dabort_valid", o_valid, 0);
        check("dabort_done", o_done, 0);
        check("dabort_busy", o_busy, 1);
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (o_done || o_valid) dones++;
        end
        check("dabort_quiet", dones, 0);
        i_ready = 1'b1;
        send_frame(ab_in);
        collect(1'b0, dones, span);
        expect_stream("dabort", ab_ex);

        // i_en in IDLE
        i_P = 999; i_en = 1'b1; tick(); i_en = 1'b0;
        check("idle_err", o_err, 1);
        check("idle_busy", o_busy, 0);
        start_pulse(1'b0);
        check("err_cleared", o_err, 0);

        // 10th sample in frame, plus i_en during drain stall
        send_frame(nom_in);
        i_P = 1600; i_en = 1'b1; tick(); i_en = 1'b0;
        check("extra_err", o_err, 1);
        i_ready = 1'b0;
        wait_valid("extra_valid_up");
        i_P = 1584; i_en = 1'b1; tick(); i_en = 1'b0;
        collect(1'b1, dones, span);
        expect_stream("extra", nom_ex);
        check("extra_err_sticky", o_err, 1);
        check("extra_dones", dones, 1);

        // Reset overrides start/en mid-collect
        start_pulse(1'b0);
        for (int k = 0; k < 3; k++) begin
            i_P = 16; i_en = 1'b1; tick();
        end
        i_rst = 1'b1; i_start = 1'b1; i_en = 1'b1;
        tick();
        i_rst = 1'b0; i_start = 1'b0; i_en = 1'b0;
        check("mrst_busy", o_busy, 0);
        check("mrst_err", o_err, 0);
        check("mrst_valid", o_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
